// File: rtl/fc_param_stream.sv
// Streaming fully-connected layer: loads an N-element x vector, computes M dot
// products against a resident weight memory, P rows at a time, and streams results.
module fc_param_stream #(
  parameter int M    = 10,
  parameter int N    = 8,
  parameter int T    = 16,
  parameter int P    = 2,
  parameter int RELU = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         input_valid,
  output logic                         input_ready,
  input  logic signed [T-1:0]          input_data,
  output logic                         output_valid,
  input  logic                         output_ready,
  output logic signed [T-1:0]          output_data,
  input  logic                         w_wr_en,
  input  logic [$clog2(M*N)-1:0]       w_addr,
  input  logic signed [T-1:0]          w_data
);

  localparam int ADDRW = $clog2(M*N);
  localparam int AW    = 2*T + $clog2(N);
  localparam int G     = M / P;
  localparam int KW    = (N > 1) ? $clog2(N) : 1;
  localparam int CW    = $clog2(N + 2);
  localparam int GW    = (G > 1) ? $clog2(G) : 1;
  localparam int DW    = (P > 1) ? $clog2(P) : 1;

  localparam logic signed [AW-1:0] MAXV = {{(AW-T+1){1'b0}}, {(T-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-T+1){1'b1}}, {(T-1){1'b0}}};

  if (M % P != 0) begin : g_bad_p
    $error("fc_param_stream: M must be a multiple of P");
  end

  typedef enum logic [1:0] {LOAD_X, COMPUTE, DRAIN} state_t;

  state_t state, state_nx;

  logic [KW-1:0]        k;
  logic [CW-1:0]        c;
  logic [GW-1:0]        g;
  logic [DW-1:0]        d;

  logic signed [T-1:0]  wmem  [M*N];
  logic signed [T-1:0]  xmem  [N];
  logic signed [T-1:0]  rdata [P];
  logic signed [AW-1:0] acc   [P];
  logic signed [AW-1:0] prod  [P];
  logic signed [T-1:0]  obuf  [P];
  logic [ADDRW-1:0]     raddr [P];

  logic          in_hs, out_hs, last_x, last_out, last_grp, mac_en, mac_done;
  logic [CW-1:0] jr;
  logic [KW-1:0] xi;
  logic signed [T-1:0] xcur;

  function automatic logic signed [T-1:0] sat(input logic signed [AW-1:0] a);
    logic signed [T-1:0] r;
    if (a > MAXV)      r = MAXV[T-1:0];
    else if (a < MINV) r = MINV[T-1:0];
    else               r = a[T-1:0];
    if (RELU != 0 && r < 0) r = '0;
    return r;
  endfunction

  assign in_hs    = input_valid && input_ready;
  assign out_hs   = output_valid && output_ready;
  assign last_x   = in_hs && (k == KW'(N-1));
  assign last_out = out_hs && (d == DW'(P-1));
  assign last_grp = (g == GW'(G-1));
  // c=0 issues the first read; c=1..N accumulate; c=N+1 latches the results
  assign mac_en   = (state == COMPUTE) && (c != '0) && (c <= CW'(N));
  assign mac_done = (state == COMPUTE) && (c == CW'(N+1));
  assign jr       = (c < CW'(N)) ? c : '0;
  assign xi       = KW'(c - CW'(1));
  assign xcur     = mac_en ? xmem[xi] : '0;

  always_comb begin
    for (int unsigned l = 0; l < P; l++) begin
      raddr[l] = ADDRW'((int'(g) * P + l) * N + int'(jr));
      prod[l]  = rdata[l] * xcur;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LOAD_X;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    input_ready  = 1'b0;
    output_valid = 1'b0;
    output_data  = '0;
    case (state)
      LOAD_X: begin
        input_ready = 1'b1;
        if (last_x) state_nx = COMPUTE;
      end
      COMPUTE: begin
        if (mac_done) state_nx = DRAIN;
      end
      DRAIN: begin
        output_valid = 1'b1;
        output_data  = obuf[d];
        if (last_out) state_nx = last_grp ? LOAD_X : COMPUTE;
      end
      default: state_nx = LOAD_X;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k <= '0;
      c <= '0;
      g <= '0;
      d <= '0;
      for (int unsigned l = 0; l < P; l++) begin
        acc[l]  <= '0;
        obuf[l] <= '0;
      end
    end else begin
      case (state)
        LOAD_X: begin
          c <= '0;
          if (in_hs) k <= last_x ? '0 : k + 1'b1;
        end
        COMPUTE: begin
          c <= mac_done ? '0 : c + 1'b1;
          for (int unsigned l = 0; l < P; l++) begin
            if (c == '0)  acc[l] <= '0;
            else if (mac_en) acc[l] <= acc[l] + prod[l];
            if (mac_done) obuf[l] <= sat(acc[l]);
          end
          if (mac_done) d <= '0;
        end
        DRAIN: begin
          if (out_hs) begin
            if (last_out) begin
              d <= '0;
              g <= last_grp ? '0 : g + 1'b1;
            end else begin
              d <= d + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Storage without reset: weights persist across reset, x is always rewritten before use
  always_ff @(posedge clk) begin
    if (w_wr_en && state == LOAD_X) wmem[w_addr] <= w_data;
    if (in_hs) xmem[k] <= input_data;
    for (int unsigned l = 0; l < P; l++) rdata[l] <= wmem[raddr[l]];
  end

endmodule

// File: tb/tb_fc_param_stream.sv
// Randomized self-checking bench for fc_param_stream (M=4, N=3, T=8, P=2) with
// plain and RELU instances driven in lockstep against an arithmetic reference.
module tb_fc_param_stream;

  logic              clk = 1'b0;
  logic              reset;
  logic              input_valid, input_ready, input_ready_r;
  logic signed [7:0] input_data;
  logic              output_valid, output_valid_r, output_ready;
  logic signed [7:0] output_data, output_data_r;
  logic              w_wr_en;
  logic [3:0]        w_addr;
  logic signed [7:0] w_data;

  int wm [12];
  int xv [3];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fc_param_stream #(.M(4), .N(3), .T(8), .P(2), .RELU(0)) dut (
    .clk(clk), .reset(reset),
    .input_valid(input_valid), .input_ready(input_ready), .input_data(input_data),
    .output_valid(output_valid), .output_ready(output_ready), .output_data(output_data),
    .w_wr_en(w_wr_en), .w_addr(w_addr), .w_data(w_data)
  );

  fc_param_stream #(.M(4), .N(3), .T(8), .P(2), .RELU(1)) dut_r (
    .clk(clk), .reset(reset),
    .input_valid(input_valid), .input_ready(input_ready_r), .input_data(input_data),
    .output_valid(output_valid_r), .output_ready(output_ready), .output_data(output_data_r),
    .w_wr_en(w_wr_en), .w_addr(w_addr), .w_data(w_data)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int ref_row(input int row, input bit relu);
    int s = 0;
    for (int j = 0; j < 3; j++) s += wm[row*3 + j] * xv[j];
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
    if (relu && s < 0) s = 0;
    return s;
  endfunction

  // mode 0: constant v, 1: row i holds i+1, 2: random
  task automatic load_w(input int mode, input int v);
    for (int a = 0; a < 12; a++) begin
      case (mode)
        0:       wm[a] = v;
        1:       wm[a] = a / 3 + 1;
        default: wm[a] = int'($urandom_range(0, 255)) - 128;
      endcase
      w_wr_en = 1'b1;
      w_addr  = 4'(a);
      w_data  = 8'(wm[a]);
      @(negedge clk);
    end
    w_wr_en = 1'b0;
  endtask

  task automatic send_vec(input int a, input int b, input int c, input bit wr_mid);
    int n;
    xv[0] = a; xv[1] = b; xv[2] = c;
    for (int j = 0; j < 3; j++) begin
      if ($urandom_range(0, 3) == 0) begin
        input_valid = 1'b0;
        input_data  = 8'($urandom);
        @(negedge clk);
      end
      input_valid = 1'b1;
      input_data  = 8'(xv[j]);
      if (j == 0) check("in_ready_load", int'(input_ready), 1);
      @(negedge clk);
    end
    input_valid = 1'b0;
    check("in_ready_compute", int'(input_ready), 0);
    if (wr_mid) begin
      w_wr_en = 1'b1;
      w_addr  = 4'd0;
      w_data  = 8'sd50;
    end
    n = 0;
    while (!output_valid && n < 50) begin
      @(negedge clk);
      w_wr_en = 1'b0;
      n++;
    end
    check("first_latency", n, 5);
  endtask

  // mode 0: always ready, 1: random ready, 2: stall 10 cycles on row 0 then ready
  task automatic recv(input int mode, input int nrows);
    int row = 0, gap = 0, budget = 0, stall = 0, hold = 0;
    bit rdy;
    while (row < nrows && budget < 500) begin
      if (!output_valid) begin
        output_ready = 1'b0;
        gap++;
      end else begin
        if (gap > 0) begin
          check("group_latency", gap, 5);
          gap = 0;
        end
        if (mode == 2 && row == 0 && stall < 10) begin
          rdy = 1'b0;
          if (stall == 0) hold = int'(output_data);
          else check("stall_hold", int'(output_data), hold);
          stall++;
        end else if (mode == 1) begin
          rdy = 1'($urandom_range(0, 1));
        end else begin
          rdy = 1'b1;
        end
        output_ready = rdy;
        if (rdy) begin
          check($sformatf("row%0d", row), int'(output_data), ref_row(row, 1'b0));
          check($sformatf("relu_row%0d", row), int'(output_data_r), ref_row(row, 1'b1));
          check("relu_valid", int'(output_valid_r), 1);
          row++;
        end
      end
      @(negedge clk);
      budget++;
    end
    output_ready = 1'b0;
    check("rows_delivered", row, nrows);
    if (nrows == 4) check("back_to_load", int'(input_ready), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    input_valid = 1'b0; input_data = '0; output_ready = 1'b0;
    w_wr_en = 1'b0; w_addr = '0; w_data = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", int'(output_valid), 0);
    check("rst_data", int'(output_data), 0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_in_ready", int'(input_ready), 1);

    load_w(0, 1);
    send_vec(1, 2, 3, 1'b0);
    recv(0, 4);

    load_w(1, 0);
    send_vec(-1, -1, -1, 1'b0);
    recv(0, 4);

    load_w(0, 127);
    send_vec(127, 127, 127, 1'b0);
    recv(1, 4);
    load_w(0, -128);
    send_vec(127, 127, 127, 1'b0);
    recv(0, 4);

    load_w(0, 1);
    send_vec(1, 2, 3, 1'b0);
    recv(2, 4);
    send_vec(3, -2, 1, 1'b0);
    recv(1, 4);

    // weight write while busy must be ignored for this and the next vector
    send_vec(5, 7, 9, 1'b1);
    recv(0, 4);
    send_vec(-4, 2, 6, 1'b0);
    recv(1, 4);

    // reset in the middle of draining
    send_vec(1, 2, 3, 1'b0);
    recv(0, 1);
    reset = 1'b0;
    #1;
    check("midrst_valid", int'(output_valid), 0);
    check("midrst_data", int'(output_data), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", int'(input_ready), 1);
    check("midrst_in_ready_r", int'(input_ready_r), 1);
    check("midrst_valid_after", int'(output_valid), 0);
    send_vec(1, 2, 3, 1'b0);
    recv(0, 4);

    for (int it = 0; it < 6; it++) begin
      load_w(2, 0);
      send_vec(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
               int'($urandom_range(0, 255)) - 128, 1'b0);
      recv(1, 4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fc_param_stream.md
FC_PARAM_STREAM -- requirements
Module: fc_param_stream

Interface
REQ-001 Parameter M, default 10, number of output rows.
REQ-002 Parameter N, default 8, input vector length.
REQ-003 Parameter T, default 16, signed data width of inputs, weights and outputs.
REQ-004 Parameter P, default 2, parallel MAC lanes; M SHALL be a multiple of P, otherwise elaboration fails.
REQ-005 Parameter RELU, default 0, 1 = outputs clamped at zero from below.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 input_valid  in  1, input_ready  out  1, input_data  in  T signed: x-vector stream.
REQ-009 output_valid  out  1, output_ready  in  1, output_data  out  T signed: result stream.
REQ-010 w_wr_en  in  1, w_addr  in  clog2(M*N), w_data  in  T signed: weight write port; W[i][j] at address i*N+j.

Function
REQ-011 Three-state FSM: LOAD_X, COMPUTE, DRAIN; LOAD_X is the reset state.
REQ-012 LOAD_X: input_ready=1; each input_valid&&input_ready cycle writes input_data to x[k], k = 0..N-1 in order.
REQ-013 LOAD_X exits to COMPUTE on the handshake accepting x[N-1]; input_ready is 0 in COMPUTE and DRAIN.
REQ-014 Weight writes take effect only in LOAD_X; w_wr_en in COMPUTE or DRAIN is ignored, memory unchanged.
REQ-015 Weight memory persists across vectors; reset does not clear it; unwritten contents undefined.
REQ-016 COMPUTE processes row group g (rows g*P .. g*P+P-1): 1 cycle memory-read latency, then N MAC cycles, all P lanes in parallel.
REQ-017 Each lane accumulator is 2T+clog2(N) bits signed, cleared at group start, adds full-precision T x T products; no intermediate overflow.
REQ-018 Result = accumulator saturated to [-2^(T-1), 2^(T-1)-1]; if RELU=1, negative results SHALL become 0.
REQ-019 After the last MAC, P results latch into an output buffer; FSM enters DRAIN.
REQ-020 DRAIN: output_valid=1, output_data = buffer entry for the lowest undelivered row; advance one entry per output_valid&&output_ready cycle.
REQ-021 While output_valid=1 and output_ready=0, output_data SHALL hold stable.
REQ-022 After entry P-1 handshakes: if g < M/P-1, go to COMPUTE with g+1; else go to LOAD_X with k=0, g=0.
REQ-023 Timing: first output_valid rises exactly N+2 cycles after the x[N-1] handshake edge; each subsequent group's output_valid rises N+2 cycles after the previous group's final handshake.
REQ-024 Outputs delivered strictly in row order 0..M-1, exactly M per input vector.
REQ-025 input_valid without input_ready has no effect; x memory is not written.

Reset
REQ-026 reset low SHALL immediately force: state LOAD_X, k=0, g=0, accumulators 0, input_ready=1 after release, output_valid=0, output_data=0.
REQ-027 Reset during COMPUTE or DRAIN abandons the vector; no partial results emitted after release.
REQ-028 Reset deassertion is synchronised to clk by the integrator; the block requires reset low for at least one clk edge.

Verification
REQ-029 M=4,N=3,T=8,P=2,RELU=0; all W=1; x=1,2,3 -> outputs 6,6,6,6; first output_valid 5 cycles after x[2] accepted.
REQ-030 Same config, W row i = i+1 for all j, x=-1,-1,-1 -> -3,-6,-9,-12; rerun with RELU=1 -> 0,0,0,0.
REQ-031 All W=127, x=127,127,127 -> each output 127 (saturation); W=-128, x=127 -> each -128.
REQ-032 output_ready held 0 for 10 cycles with output_valid=1 -> output_data unchanged, no row skipped; random ready toggling -> 4 outputs in order.
REQ-033 w_wr_en pulsed to address 0 with value 50 during COMPUTE -> current and next vector results use old W[0][0].
REQ-034 reset asserted mid-DRAIN after row 0 delivered -> output_valid=0 immediately, input_ready=1 after release; fresh vector x=1,2,3 gives 6,6,6,6.
